sha1_msg_schedule: RTL
======================

# sha1_msg_schedule

SHA-1 message-schedule stage. Accepts one 512-bit padded message block and streams the 80 schedule words W[0..79] to the round/compression stage, one word per accepted handshake. Holds a 16-word sliding window. Produces W[16..79] through the existing XOR/rotate-left-1 word generator.

## Interface
- No parameters. Word width (32), window depth (16) and round count (80) come from the `definitions` package.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `blk_valid`  in  1  upstream block available.
- `blk_data`  in  512  padded message block, big-endian; W[0] = `blk_data[511:480]`, W[15] = `blk_data[31:0]`.
- `blk_ready`  out  1  block load accepted when `blk_valid && blk_ready`.
- `w_valid`  out  1  `w_data` holds a valid schedule word.
- `w_ready`  in  1  downstream consumes the word when `w_valid && w_ready`.
- `w_data`  out  32  current schedule word W[t].
- `w_idx`  out  7  round index t, 0..79.
- `w_last`  out  1  high when `w_valid` and `w_idx == 79`.

## Operation
- States: IDLE, RUN.
- Reset value: state IDLE, window all zero, `w_idx` 0. Outputs during and after reset: `w_valid` 0, `w_last` 0, `w_data` 0, `blk_ready` 1.
- IDLE:
  - `blk_ready` = 1.
  - On block handshake: window[i] ← word i of `blk_data`, `w_idx` ← 0, go to RUN.
- RUN:
  - `w_valid` = 1, `w_data` = window[0], `blk_ready` = 0 (except as noted under Configuration).
  - Word handshake with `w_idx < 79`: window[i] ← window[i+1] for i = 0..14, window[15] ← rotl1(window[13] ^ window[8] ^ window[2] ^ window[0]), `w_idx` ← `w_idx` + 1.
  - This yields W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]).
- Word handshake with `w_idx == 79`: go to IDLE, `w_idx` ← 0. Window contents are don't-care.
- `w_valid && !w_ready`: all state holds; `w_data` and `w_idx` are stable.
- `blk_valid` while in RUN is ignored; no load occurs and `blk_data` is not sampled.
- Reset mid-block: the block is abandoned and state returns immediately to the reset values. No partial words are emitted after reset deasserts.
- Arithmetic: `w_idx` never exceeds 79. All word operations are 32-bit with no carries.

## Timing
- Block handshake in cycle N → `w_valid` = 1 with W[0] in cycle N+1.
- With `w_ready` held high: W[t] appears in cycle N+1+t, and W[79] with `w_last` appears in cycle N+80.
- `w_data`, `w_idx` and `w_valid` are registered outputs.
- `w_last` is decoded from registered `w_idx`.
- `blk_ready` is combinational from state, and also from `w_ready` when the Configuration macro is defined. No combinational path exists from `blk_valid` to any output.
- Throughput without the macro: 81 cycles per block (one IDLE bubble).

## Configuration
- Macro: `SHA1_SCHED_BACK2BACK_EN`.
- Defined:
  - In RUN with `w_idx == 79`, `blk_ready` = `w_ready`.
  - If the final word handshake and a block handshake occur in the same cycle, the new block is loaded, `w_idx` ← 0 and state stays RUN.
  - W[0] of the new block appears the next cycle, giving 80 cycles per block.
  - If `blk_valid` is low at that point, behaviour is as without the macro.
- Not defined: `blk_ready` = 1 only in IDLE. Every block is followed by one cycle with `w_valid` = 0.

## Structure
- `definitions` package holds:
  - `WORD_W` = 32, `SCHED_DEPTH` = 16, `SHA1_ROUNDS` = 80.
  - `typedef logic [31:0] word_t`.
  - `typedef enum logic {SCHED_IDLE, SCHED_RUN} sched_state_t`.
- Single sub-module: `sha1_new_block`, combinational and instantiated once. Inputs are window[13], window[8], window[2], window[0]; its output feeds window[15].
- All remaining logic (window, index counter, FSM) lives in this module.

## Test plan
- "abc" block (0x61626380, 14 × 0x00000000, 0x00000018), `w_ready` = 1:
  - W0 = 0x61626380, W15 = 0x00000018, W16 = 0xC2C4C700, W17 = 0x00000000, W18 = 0x00000030.
  - All 80 words match a software model; `w_last` is high only at idx 79, in cycle N+80.
- Random `w_ready` stalls on the same block: word sequence is identical, and `w_data`/`w_idx` are stable across every stall cycle.
- Two blocks offered back-to-back with `blk_valid` held high:
  - Without the macro: exactly one cycle of `w_valid` = 0 between idx 79 and the next idx 0.
  - With the macro: zero idle cycles.
- `blk_valid` pulsed during RUN at idx 40: no effect on the stream, `blk_ready` stays 0.
- `reset` asserted at idx 37 for one cycle: `w_valid` = 0 and `w_idx` = 0 immediately (asynchronous). The next block then streams correctly from W0.
- All-ones block (16 × 0xFFFFFFFF): W16 = rotl1(0) = 0x00000000, W19 = 0xFFFFFFFF. Checks that the rotate/XOR taps are correct.

Source files
------------

// File: rtl/sha1_msg_schedule_pkg.sv
// Shared types and constants for the SHA-1 message schedule.
// The optional SHA1_SCHED_BACK2BACK_EN feature is handled in sha1_msg_schedule.sv.
package definitions;
  localparam int WORD_W      = 32;
  localparam int SCHED_DEPTH = 16;
  localparam int SHA1_ROUNDS = 80;
  localparam logic [6:0] LAST_IDX = 7'(SHA1_ROUNDS - 1);

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic {SCHED_IDLE, SCHED_RUN} sched_state_t;

  function automatic word_t rotl1(input word_t x);
    return {x[WORD_W-2:0], x[WORD_W-1]};
  endfunction
endpackage

// File: rtl/sha1_new_block.sv
// Combinational SHA-1 schedule word generator: rotl1(w13 ^ w8 ^ w2 ^ w0).
module sha1_new_block
  import definitions::*;
(
  input  word_t i_w13,
  input  word_t i_w8,
  input  word_t i_w2,
  input  word_t i_w0,
  output word_t o_new
);
  assign o_new = rotl1(i_w13 ^ i_w8 ^ i_w2 ^ i_w0);
endmodule

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: loads one 512-bit block and streams W[0..79].
// Define SHA1_SCHED_BACK2BACK_EN to accept the next block on the final word handshake.
//
// Handshakes: a transfer occurs on a rising edge where valid && ready are both
// high; a producer holding valid keeps its data stable until that edge.
module sha1_msg_schedule
  import definitions::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  input  logic [511:0] blk_data,
  output logic         blk_ready,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [6:0]   w_idx,
  output logic         w_last,
  output sched_state_t dbg_state
);
  sched_state_t r_state;
  word_t        r_win [SCHED_DEPTH];
  logic [6:0]   r_idx;

  word_t w_new_word;
  logic  w_word_hs;
  logic  w_blk_hs;
  logic  w_is_last;

  sha1_new_block u_new_block (
    .i_w13 (r_win[13]),
    .i_w8  (r_win[8]),
    .i_w2  (r_win[2]),
    .i_w0  (r_win[0]),
    .o_new (w_new_word)
  );

  assign w_valid   = (r_state == SCHED_RUN);
  assign w_data    = r_win[0];
  assign w_idx     = r_idx;
  assign w_is_last = (r_idx == LAST_IDX);
  assign w_last    = w_valid && w_is_last;
  assign w_word_hs = w_valid && w_ready;
  assign w_blk_hs  = blk_valid && blk_ready;
  assign dbg_state = r_state;

  always_comb begin
    blk_ready = (r_state == SCHED_IDLE);
`ifdef SHA1_SCHED_BACK2BACK_EN
    if (r_state == SCHED_RUN && w_is_last) blk_ready = w_ready;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SCHED_IDLE;
      r_idx   <= '0;
      for (int i = 0; i < SCHED_DEPTH; i++) r_win[i] <= '0;
    end else begin
      case (r_state)
        SCHED_IDLE: begin
          if (w_blk_hs) begin
            for (int i = 0; i < SCHED_DEPTH; i++) r_win[i] <= blk_data[511-32*i -: 32];
            r_idx   <= '0;
            r_state <= SCHED_RUN;
          end
        end
        SCHED_RUN: begin
          if (w_word_hs) begin
            if (!w_is_last) begin
              for (int i = 0; i < SCHED_DEPTH - 1; i++) r_win[i] <= r_win[i+1];
              r_win[SCHED_DEPTH-1] <= w_new_word;
              r_idx <= r_idx + 7'd1;
            end else begin
              r_idx   <= '0;
              r_state <= SCHED_IDLE;
`ifdef SHA1_SCHED_BACK2BACK_EN
              // Final word and next block in the same cycle: reload without a bubble.
              if (w_blk_hs) begin
                for (int i = 0; i < SCHED_DEPTH; i++) r_win[i] <= blk_data[511-32*i -: 32];
                r_state <= SCHED_RUN;
              end
`endif
            end
          end
        end
        default: r_state <= SCHED_IDLE;
      endcase
    end
  end
endmodule
